// File: rtl/midi_note_rx.sv
// MIDI receiver: oversampled UART byte recovery feeding a Note On/Off parser with channel filter.
// Define MIDI_RUNNING_STATUS_EN to keep status after each message so bare data-byte pairs emit more notes.
module midi_note_rx #(
    parameter int BIT_DIV = 128,
    parameter int CHANNEL = 0,
    parameter bit OMNI    = 1'b0
) (
    input  logic       clk,
    input  logic       r,
    input  logic       midi_in,
    output logic       msg_valid,
    output logic       note_on,
    output logic [3:0] chan,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic       framing_err
);

    localparam int              CW        = $clog2(BIT_DIV);
    localparam logic [CW-1:0]   HALF_LOAD = CW'(BIT_DIV / 2 - 1);
    localparam logic [CW-1:0]   FULL_LOAD = CW'(BIT_DIV - 1);
    localparam logic [3:0]      CHAN_SEL  = 4'(CHANNEL);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;
    typedef enum logic [1:0] {P_WAIT_STATUS, P_WAIT_D1, P_WAIT_D2} parseState_e;

    rxState_e    rxState_q, rxState_d;
    logic [CW-1:0] bitCnt_q, bitCnt_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [7:0]  shift_q, shift_d;
    logic        sync1_q, rx_q, rxPrev_q;
    logic        framingErr_q;
    logic        byteValid, stopBad;

    parseState_e parseState_q, parseState_d;
    logic        statusOn_q, statusOn_d;
    logic [3:0]  chanLatch_q, chanLatch_d;
    logic [6:0]  noteLatch_q, noteLatch_d;
    logic        msgValid_q, noteOn_q;
    logic [3:0]  chan_q;
    logic [6:0]  note_q, velocity_q;
    logic        emit, emitNoteOn;
    logic        isRealtime, isNoteStatus, chanMatch;

    // Receiver state register; rx_q is the second synchroniser stage, rxPrev_q its history for edge detection.
    always_ff @(posedge clk) begin
        if (r) begin
            rxState_q    <= RX_IDLE;
            bitCnt_q     <= '0;
            bitIdx_q     <= '0;
            shift_q      <= '0;
            sync1_q      <= 1'b1;
            rx_q         <= 1'b1;
            rxPrev_q     <= 1'b1;
            framingErr_q <= 1'b0;
        end else begin
            rxState_q    <= rxState_d;
            bitCnt_q     <= bitCnt_d;
            bitIdx_q     <= bitIdx_d;
            shift_q      <= shift_d;
            sync1_q      <= midi_in;
            rx_q         <= sync1_q;
            rxPrev_q     <= rx_q;
            framingErr_q <= stopBad;
        end
    end

    always_comb begin
        rxState_d = rxState_q;
        bitCnt_d  = bitCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        case (rxState_q)
            RX_IDLE: begin
                if (rxPrev_q && !rx_q) begin
                    rxState_d = RX_START;
                    bitCnt_d  = HALF_LOAD;
                end
            end
            RX_START: begin
                if (bitCnt_q == '0) begin
                    if (rx_q) begin
                        rxState_d = RX_IDLE;
                    end else begin
                        rxState_d = RX_DATA;
                        bitCnt_d  = FULL_LOAD;
                        bitIdx_d  = '0;
                    end
                end else begin
                    bitCnt_d = bitCnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (bitCnt_q == '0) begin
                    // LSB arrives first, so shift in from the top.
                    shift_d  = {rx_q, shift_q[7:1]};
                    bitCnt_d = FULL_LOAD;
                    bitIdx_d = bitIdx_q + 1'b1;
                    if (bitIdx_q == 3'd7) begin
                        rxState_d = RX_STOP;
                    end
                end else begin
                    bitCnt_d = bitCnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (bitCnt_q == '0) begin
                    rxState_d = RX_IDLE;
                end else begin
                    bitCnt_d = bitCnt_q - 1'b1;
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    always_comb begin
        byteValid = 1'b0;
        stopBad   = 1'b0;
        if (rxState_q == RX_STOP && bitCnt_q == '0) begin
            byteValid = rx_q;
            stopBad   = !rx_q;
        end
    end

    // Parser and output registers; the message fields only move on an emit.
    always_ff @(posedge clk) begin
        if (r) begin
            parseState_q <= P_WAIT_STATUS;
            statusOn_q   <= 1'b0;
            chanLatch_q  <= '0;
            noteLatch_q  <= '0;
            msgValid_q   <= 1'b0;
            noteOn_q     <= 1'b0;
            chan_q       <= '0;
            note_q       <= '0;
            velocity_q   <= '0;
        end else begin
            parseState_q <= parseState_d;
            statusOn_q   <= statusOn_d;
            chanLatch_q  <= chanLatch_d;
            noteLatch_q  <= noteLatch_d;
            msgValid_q   <= emit;
            if (emit) begin
                noteOn_q   <= emitNoteOn;
                chan_q     <= chanLatch_q;
                note_q     <= noteLatch_q;
                velocity_q <= shift_q[6:0];
            end
        end
    end

    always_comb begin
        isRealtime   = (shift_q[7:3] == 5'b11111);
        isNoteStatus = (shift_q[7:5] == 3'b100);
        chanMatch    = OMNI || (shift_q[3:0] == CHAN_SEL);
    end

    always_comb begin
        parseState_d = parseState_q;
        statusOn_d   = statusOn_q;
        chanLatch_d  = chanLatch_q;
        noteLatch_d  = noteLatch_q;
        if (byteValid) begin
            if (shift_q[7]) begin
                if (isRealtime) begin
                    parseState_d = parseState_q;
                end else if (isNoteStatus && chanMatch) begin
                    parseState_d = P_WAIT_D1;
                    statusOn_d   = shift_q[4];
                    chanLatch_d  = shift_q[3:0];
                end else begin
                    parseState_d = P_WAIT_STATUS;
                    statusOn_d   = 1'b0;
                    chanLatch_d  = '0;
                end
            end else begin
                case (parseState_q)
                    P_WAIT_D1: begin
                        noteLatch_d  = shift_q[6:0];
                        parseState_d = P_WAIT_D2;
                    end
                    P_WAIT_D2: begin
`ifdef MIDI_RUNNING_STATUS_EN
                        parseState_d = P_WAIT_D1;
`else
                        parseState_d = P_WAIT_STATUS;
                        statusOn_d   = 1'b0;
                        chanLatch_d  = '0;
`endif
                    end
                    default: parseState_d = parseState_q;
                endcase
            end
        end
    end

    always_comb begin
        emit       = byteValid && !shift_q[7] && (parseState_q == P_WAIT_D2);
        emitNoteOn = statusOn_q && (shift_q[6:0] != 7'd0);
    end

    assign msg_valid   = msgValid_q;
    assign note_on     = noteOn_q;
    assign chan        = chan_q;
    assign note        = note_q;
    assign velocity    = velocity_q;
    assign framing_err = framingErr_q;

endmodule

// File: doc/midi_note_rx.md
# midi_note_rx

Parametrised MIDI receiver and note-message parser: oversampled UART byte recovery with start-bit validation and stop-bit checking, then assembly of Note On/Off messages with a channel filter. It sits between the raw MIDI opto-isolator line and the LED/display logic, and replaces the fixed shift-register decode and frame counting. It emits one pulse per complete note message.

## Interface
Parameters:
- `BIT_DIV`, 128 — clk cycles per MIDI bit (4 MHz / 31.25 kbaud); must be even and ≥ 4.
- `CHANNEL`, 0 — MIDI channel accepted, 0–15.
- `OMNI`, 0 — 1 accepts all channels and ignores `CHANNEL`.

Ports:
- `clk` input 1 — sole clock.
- `r` input 1 — synchronous, active-high reset.
- `midi_in` input 1 — raw asynchronous serial line, idle high.
- `msg_valid` output 1 — one-cycle pulse when a note message completes.
- `note_on` output 1 — 1 = Note On with velocity ≠ 0; 0 = Note Off, or Note On with velocity 0.
- `chan` output 4 — channel of the message.
- `note` output 7 — note number.
- `velocity` output 7 — velocity.
- `framing_err` output 1 — one-cycle pulse when a stop bit samples 0.

## Operation
- **Synchroniser:** two flops on `midi_in`, both reset to 1. All logic uses the synchronised output `rx`.
- **Receiver FSM:**
  - IDLE: `rx` 1→0 (previous 1, current 0) → START, and the bit counter loads `BIT_DIV/2 - 1`.
  - START: when the counter reaches 0, sample `rx`. If 1 (glitch) → IDLE. Otherwise → DATA with counter `BIT_DIV - 1`.
  - DATA: sample 8 bits LSB-first, one every `BIT_DIV` cycles, then → STOP.
  - STOP: sample. If 1, assert internal `byte_valid` for one cycle; if 0, pulse `framing_err` and drop the byte. Both cases → IDLE.
  - Counter width is `$clog2(BIT_DIV)`.
- **Parser** (acts on `byte_valid`), states WAIT_STATUS, WAIT_D1, WAIT_D2:
  - `0xF8`–`0xFF` (real-time): ignored, no state change.
  - `0x8n` / `0x9n` with channel match (or `OMNI`): latch status and channel → WAIT_D1.
  - Any other status `0x80`–`0xF7`: clear latched status → WAIT_STATUS.
  - Data byte (bit 7 = 0):
    - In WAIT_STATUS: ignored.
    - In WAIT_D1: latch note → WAIT_D2.
    - In WAIT_D2: latch velocity and emit the message. `note_on = (status[7:4] == 9) && (velocity != 0)`.
  - After emit: running-status behaviour per Configuration.
- **Outputs:** `note`, `velocity`, `note_on` and `chan` are registered and update only with `msg_valid`; they hold their values otherwise.
- **Reset:** all outputs 0, receiver IDLE, parser WAIT_STATUS, status cleared. Reset mid-byte discards the partial byte. Reset wins over any simultaneous event.

## Timing
- Let T0 be the first cycle `rx` = 0, which is 2 cycles after the `midi_in` fall.
- Samples occur at T0 + `BIT_DIV/2` + k·`BIT_DIV`: k = 0 start, k = 1..8 data, k = 9 stop.
- `byte_valid` occurs in the stop-sample cycle. `msg_valid` and the updated outputs appear in the following cycle, for exactly one cycle.
- `framing_err` is asserted in the cycle after the failing stop sample.
- A new falling edge is accepted from the first cycle after returning to IDLE; back-to-back bytes with no idle gap are received.
- A start glitch shorter than `BIT_DIV/2` cycles produces no byte and no error.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined: after emit, the parser returns to WAIT_D1 and retains status/channel. Further data-byte pairs each produce a message.
- Not defined: after emit, the parser clears status and returns to WAIT_STATUS. Data bytes without a new status byte are ignored.

## Test plan
- Reset asserted for 3 cycles, `midi_in` = 1 → all outputs 0, no pulses during 2000 idle cycles.
- `BIT_DIV` = 128, bytes `90 3C 64` → single `msg_valid` with `note` = 0x3C, `velocity` = 0x64, `note_on` = 1, `chan` = 0, occurring at T0(3rd byte) + 64 + 9·128 + 1.
- `90 3C 00`, then `80 3C 40` → two pulses, both with `note_on` = 0; velocities 0x00 and 0x40.
- `90 3C 64 40 50` → with `MIDI_RUNNING_STATUS_EN`: second pulse with `note` = 0x40, `velocity` = 0x50; without the macro: exactly one pulse.
- Byte `0x90` sent with stop bit 0 → `framing_err` pulse, parser stays in WAIT_STATUS. A 20-cycle low glitch → nothing.
- `CHANNEL` = 0: `91 3C 64` → no pulse. `90 3C F8 64` → one pulse, `velocity` = 0x64 (F8 ignored). `OMNI` = 1: `91 3C 64` → pulse with `chan` = 1.
